// File: rtl/axi_uart_lite_slave.sv
// AXI4-lite slave for the UART-lite register map: RX/TX byte FIFOs, status and control.
// Offsets 0x0 RX, 0x4 TX, 0x8 STAT, 0xC CTRL; the serializer/deserializer lives outside.
module axi_uart_lite_slave #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);
    typedef enum logic [1:0] {
        REG_RX   = 2'd0,
        REG_TX   = 2'd1,
        REG_STAT = 2'd2,
        REG_CTRL = 2'd3
    } reg_sel_e;

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    logic             aw_held_q, aw_held_d;
    reg_sel_e         aw_sel_q, aw_sel_d;
    logic             w_held_q, w_held_d;
    logic [7:0]       w_byte_q, w_byte_d;
    logic             w_strb0_q, w_strb0_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             overrun_q, overrun_d;
    logic [FIFO_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [FIFO_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [7:0]       tx_mem [DEPTH];
    logic [7:0]       rx_mem [DEPTH];

    logic     aw_hs, w_hs, ar_hs, wr_exec, wr_strb0;
    reg_sel_e wr_sel, rd_sel;
    logic [7:0] wr_byte;
    logic     tx_empty, tx_full, rx_empty, rx_full;
    logic     tx_push, tx_pop, tx_clr, rx_push, rx_pop, rx_clr;
    logic     unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:4], s_axi_awaddr[1:0],
                         s_axi_araddr[31:4], s_axi_araddr[1:0], s_axi_wdata[31:8], s_axi_wstrb[3:1]};

    assign s_axi_awready = !aw_held_q && !bvalid_q;
    assign s_axi_wready  = !w_held_q && !bvalid_q;
    assign s_axi_arready = !rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // A channel arriving this cycle is used directly, so same-cycle AW+W executes at once.
    assign wr_sel   = aw_held_q ? aw_sel_q : reg_sel_e'(s_axi_awaddr[3:2]);
    assign wr_byte  = w_held_q ? w_byte_q : s_axi_wdata[7:0];
    assign wr_strb0 = w_held_q ? w_strb0_q : s_axi_wstrb[0];
    assign wr_exec  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign rd_sel   = reg_sel_e'(s_axi_araddr[3:2]);

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                      (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                      (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);

    assign tx_push = wr_exec && (wr_sel == REG_TX) && wr_strb0 && !tx_full;
    assign tx_pop  = !tx_empty && tx_ready;
    assign tx_clr  = wr_exec && (wr_sel == REG_CTRL) && wr_byte[0];
    assign rx_push = rx_valid && !rx_full;
    assign rx_pop  = ar_hs && (rd_sel == REG_RX) && !rx_empty;
    assign rx_clr  = wr_exec && (wr_sel == REG_CTRL) && wr_byte[1];

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rd_q[FIFO_AW-1:0]];

    always_comb begin
        aw_held_d = aw_held_q;
        aw_sel_d  = aw_sel_q;
        w_held_d  = w_held_q;
        w_byte_d  = w_byte_q;
        w_strb0_d = w_strb0_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        tx_wr_d   = tx_wr_q;
        tx_rd_d   = tx_rd_q;
        rx_wr_d   = rx_wr_q;
        rx_rd_d   = rx_rd_q;

        if (wr_exec) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_sel_d  = reg_sel_e'(s_axi_awaddr[3:2]);
            end
            if (w_hs) begin
                w_held_d  = 1'b1;
                w_byte_d  = s_axi_wdata[7:0];
                w_strb0_d = s_axi_wstrb[0];
            end
        end

        if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
        if (wr_exec) begin
            bvalid_d = 1'b1;
            bresp_d  = ((wr_sel == REG_TX) && wr_strb0 && tx_full) ? 2'b10 : 2'b00;
        end

        if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            case (rd_sel)
                REG_RX:   rdata_d = rx_empty ? '0 : {24'b0, rx_mem[rx_rd_q[FIFO_AW-1:0]]};
                REG_STAT: rdata_d = {26'b0, overrun_q, 1'b0, tx_full, tx_empty, rx_full, !rx_empty};
                default:  rdata_d = '0;
            endcase
        end

        // CTRL flush overrides any push or pop landing on the same edge.
        if (tx_clr) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
        end else begin
            if (tx_push) tx_wr_d = tx_wr_q + PTR_ONE;
            if (tx_pop)  tx_rd_d = tx_rd_q + PTR_ONE;
        end
        if (rx_clr) begin
            rx_wr_d = '0;
            rx_rd_d = '0;
        end else begin
            if (rx_push) rx_wr_d = rx_wr_q + PTR_ONE;
            if (rx_pop)  rx_rd_d = rx_rd_q + PTR_ONE;
        end

        overrun_d = (overrun_q && !(ar_hs && (rd_sel == REG_STAT))) || (rx_valid && rx_full);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_held_q <= 1'b0;
            aw_sel_q  <= REG_RX;
            w_held_q  <= 1'b0;
            w_byte_q  <= '0;
            w_strb0_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_sel_q  <= aw_sel_d;
            w_held_q  <= w_held_d;
            w_byte_q  <= w_byte_d;
            w_strb0_q <= w_strb0_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[FIFO_AW-1:0]] <= wr_byte;
        if (rx_push) rx_mem[rx_wr_q[FIFO_AW-1:0]] <= rx_data;
    end
endmodule
